pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Drives the reset input of the system PLL and consumes its `locked` output. It pulses the PLL reset, waits for lock with a timeout and retry, and requires lock to stay stable before releasing the core reset. Any loss of lock, or a soft reset request, re-runs the whole sequence. It sits beside the PLL instance in the core top level, runs on the PLL reference clock, and gates every PLL-clocked domain's reset.

Parameters:
RST_PULSE_CYCLES, 16, cycles `pll_rst` is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before retry (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release (>=1)
CNT_W, 8, width of the saturating event counters

Ports:
refclk  in  1  sole clock (74.25 MHz reference); all logic on rising edge
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL `locked`, asynchronous to `refclk`
soft_reset_req  in  1  single-cycle request to re-run the sequence
pll_rst  out  1  drives PLL `rst`, active high
core_reset  out  1  active-high reset for PLL-clocked logic
ready  out  1  high only in RUN
retry_count  out  CNT_W  number of lock timeouts, saturating
loss_count  out  CNT_W  number of lock losses in RUN, saturating
timeout_seen  out  1  sticky; set on first timeout

Behaviour:
- `pll_locked` passes through a 2-FF synchronizer to `locked_s`, which is 2 cycles late. Only `locked_s` is used.
- One shared down-counter `cnt` has width $clog2(max(params)+1).
- States: ASSERT, WAIT_LOCK, STABLE, RUN. Outputs are registered and Moore-decoded from state.
- While `rst`=1 (synchronous):
  - state=ASSERT, cnt=RST_PULSE_CYCLES-1, both sync FFs=0.
  - pll_rst=1, core_reset=1, ready=0, counters=0, timeout_seen=0.
- ASSERT: pll_rst=1, core_reset=1.
  - Decrement cnt. At cnt==0, go to WAIT_LOCK with cnt=LOCK_TIMEOUT_CYCLES-1.
  - `pll_rst` is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, core_reset=1.
  - If locked_s=1, go to STABLE with cnt=LOCK_STABLE_CYCLES-1.
  - Else if cnt==0: go to ASSERT with cnt=RST_PULSE_CYCLES-1, retry_count+=1 (saturating at 2^CNT_W-1), timeout_seen=1.
  - Else decrement cnt.
- STABLE: pll_rst=0, core_reset=1.
  - If locked_s=0, go back to WAIT_LOCK with cnt reloaded to LOCK_TIMEOUT_CYCLES-1. This is a glitch, not a timeout; no counter changes.
  - Else if cnt==0, go to RUN. Else decrement cnt.
  - Net effect: core_reset falls LOCK_STABLE_CYCLES cycles after locked_s first rises, i.e. LOCK_STABLE_CYCLES+2 cycles after `pll_locked` rises.
- RUN: pll_rst=0, core_reset=0, ready=1.
  - If locked_s=0: go to ASSERT, loss_count+=1 (saturating). core_reset=1 on the next cycle.
  - Else if soft_reset_req=1: go to ASSERT with no counter change.
- soft_reset_req is ignored outside RUN, since a sequence is already in progress.
- Simultaneous lock loss and soft_reset_req in RUN: treated as a lock loss, so loss_count increments once.
- core_reset and ready are exact complements at all times. No state has pll_rst=1 and core_reset=0.
- Mid-operation `rst`: returns to the reset values on the next edge from any state, and clears all counters and timeout_seen.
- LOCK_STABLE_CYCLES=1: RUN is entered the cycle after STABLE is entered.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, CNT_W=8.
1. rst high 3 cycles, then low; pll_locked rises 10 cycles after rst falls -> pll_rst high for cycles 0..3 after rst falls, then low; core_reset falls and ready rises 10 cycles after the pll_locked rise (cycle 20); counters stay 0.
2. pll_locked held low -> pll_rst pulses 4 cycles every 36 cycles; retry_count =1,2,3 after each pulse; timeout_seen=1 after the first timeout.
3. In STABLE, pll_locked drops for 1 cycle at the 5th stable cycle -> no release; the 8-cycle window restarts from the next locked_s rise; counters unchanged.
4. In RUN, pll_locked falls -> core_reset=1 three cycles later (2 sync + 1 state); loss_count=1; pll_rst then pulses 4 cycles.
5. In RUN, soft_reset_req for 1 cycle, and separately soft_reset_req coincident with locked_s falling -> both re-run the sequence; loss_count increments only in the coincident case.
6. Force 300 timeouts -> retry_count saturates at 255. Assert rst mid-WAIT_LOCK -> all outputs return to reset values one edge later.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the system PLL out of reset and holds the core in reset until
//   the PLL has reported a stable lock. It pulses the PLL reset, waits for lock
//   with a timeout and retry, and requires the synchronized lock to stay high
//   for a qualification window before releasing the core. A lock loss while
//   running, or a soft reset request, restarts the whole sequence.
//
// Ports:
//   refclk          sole clock (PLL reference); everything on its rising edge
//   rst             synchronous active-high reset
//   pll_locked      PLL lock indicator, asynchronous to refclk
//   soft_reset_req  one-cycle request to re-run the sequence (honoured in RUN)
//   pll_rst         drives the PLL reset input, active high
//   core_reset      active-high reset for all PLL-clocked logic
//   ready           high only while the core is released (complement of core_reset)
//   retry_count     saturating count of lock timeouts
//   loss_count      saturating count of lock losses seen while running
//   timeout_seen    sticky flag, set on the first lock timeout
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_reset_req,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count,
  output logic             timeout_seen
);

  // One down-counter is shared by every timed phase, so it is sized for the
  // largest of the three durations.
  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] PULSE_RELOAD   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_RELOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_RELOAD  = CW'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ASSERT,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             locked_s_q, locked_s_d;
  logic [CNT_W-1:0] retry_count_q, retry_count_d;
  logic [CNT_W-1:0] loss_count_q, loss_count_d;
  logic             timeout_seen_q, timeout_seen_d;
  logic             pll_rst_q, pll_rst_d;
  logic             core_reset_q, core_reset_d;
  logic             ready_q, ready_d;

  // Next-state logic. The outputs are decoded from the next state and then
  // registered, so they change on the same edge the state does and never
  // glitch. core_reset is high in every state except RUN, which guarantees it
  // is high whenever pll_rst is.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sync_d         = pll_locked;
    locked_s_d     = sync_q;
    retry_count_d  = retry_count_q;
    loss_count_d   = loss_count_q;
    timeout_seen_d = timeout_seen_q;

    case (state_q)
      ASSERT: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_RELOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = STABLE;
          cnt_d   = STABLE_RELOAD;
        end else if (cnt_q == '0) begin
          state_d        = ASSERT;
          cnt_d          = PULSE_RELOAD;
          timeout_seen_d = 1'b1;
          if (retry_count_q != '1) begin
            retry_count_d = retry_count_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // A drop here is treated as a lock glitch: go back to waiting with a
      // fresh timeout, without counting it as a retry or a loss.
      STABLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Lock loss takes priority over a coincident soft reset request so the
      // loss is always counted.
      RUN: begin
        if (!locked_s_q) begin
          state_d = ASSERT;
          cnt_d   = PULSE_RELOAD;
          if (loss_count_q != '1) begin
            loss_count_d = loss_count_q + CNT_W'(1);
          end
        end else if (soft_reset_req) begin
          state_d = ASSERT;
          cnt_d   = PULSE_RELOAD;
        end
      end

      default: begin
        state_d = ASSERT;
        cnt_d   = PULSE_RELOAD;
      end
    endcase

    pll_rst_d    = (state_d == ASSERT);
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  // State, synchronizer and registered outputs. Reset forces the sequence
  // back to the start of the PLL reset pulse and clears all history.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q        <= ASSERT;
      cnt_q          <= PULSE_RELOAD;
      sync_q         <= 1'b0;
      locked_s_q     <= 1'b0;
      retry_count_q  <= '0;
      loss_count_q   <= '0;
      timeout_seen_q <= 1'b0;
      pll_rst_q      <= 1'b1;
      core_reset_q   <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync_q         <= sync_d;
      locked_s_q     <= locked_s_d;
      retry_count_q  <= retry_count_d;
      loss_count_q   <= loss_count_d;
      timeout_seen_q <= timeout_seen_d;
      pll_rst_q      <= pll_rst_d;
      core_reset_q   <= core_reset_d;
      ready_q        <= ready_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset   = core_reset_q;
  assign ready        = ready_q;
  assign retry_count  = retry_count_q;
  assign loss_count   = loss_count_q;
  assign timeout_seen = timeout_seen_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Self-checking bench for pll_reset_sequencer. Two instances share the same
//   stimulus: one with an 8-cycle stability window and one with a 1-cycle
//   window. A behavioural model tracks, per instance, which phase of the
//   bring-up sequence the PLL is in and how long it has been there, and every
//   output is compared against it each cycle.
module tb_pll_reset_sequencer;

  localparam int PULSE = 4;
  localparam int TMO   = 32;
  localparam int STB_A = 8;
  localparam int STB_B = 1;
  localparam int CW    = 8;
  localparam int SAT   = 255;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_QUAL  = 2;
  localparam int PH_UP    = 3;

  typedef struct {
    int phase;
    int age;
    bit s1;
    bit s2;
    int retries;
    int losses;
    bit tseen;
  } mdl_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          soft_reset_req = 1'b0;

  logic          pll_rst_a, core_reset_a, ready_a, timeout_seen_a;
  logic [CW-1:0] retry_count_a, loss_count_a;
  logic          pll_rst_b, core_reset_b, ready_b, timeout_seen_b;
  logic [CW-1:0] retry_count_b, loss_count_b;

  mdl_t ma;
  mdl_t mb;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(PULSE), .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES(STB_A), .CNT_W(CW)
  ) dut_a (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst_a), .core_reset(core_reset_a), .ready(ready_a),
    .retry_count(retry_count_a), .loss_count(loss_count_a), .timeout_seen(timeout_seen_a)
  );

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(PULSE), .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES(STB_B), .CNT_W(CW)
  ) dut_b (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst_b), .core_reset(core_reset_b), .ready(ready_b),
    .retry_count(retry_count_b), .loss_count(loss_count_b), .timeout_seen(timeout_seen_b)
  );

  // Advance the model by one clock edge. 'age' is the number of edges already
  // spent in the current phase; the lock seen by the sequencer is the value
  // of pll_locked sampled two edges earlier.
  function automatic mdl_t mdlStep(input mdl_t m, input bit r, input bit l,
                                   input bit s, input int stab);
    mdl_t n;
    bit   ls;
    n = m;
    if (r) begin
      n.phase = PH_PULSE; n.age = 0; n.s1 = 1'b0; n.s2 = 1'b0;
      n.retries = 0; n.losses = 0; n.tseen = 1'b0;
      return n;
    end
    ls   = m.s2;
    n.s2 = m.s1;
    n.s1 = l;
    case (m.phase)
      PH_PULSE: begin
        if (m.age + 1 >= PULSE) begin n.phase = PH_WAIT; n.age = 0; end
        else n.age = m.age + 1;
      end
      PH_WAIT: begin
        if (ls) begin
          n.phase = PH_QUAL; n.age = 0;
        end else if (m.age + 1 >= TMO) begin
          n.phase = PH_PULSE; n.age = 0; n.tseen = 1'b1;
          n.retries = (m.retries < SAT) ? m.retries + 1 : SAT;
        end else n.age = m.age + 1;
      end
      PH_QUAL: begin
        if (!ls) begin n.phase = PH_WAIT; n.age = 0; end
        else if (m.age + 1 >= stab) begin n.phase = PH_UP; n.age = 0; end
        else n.age = m.age + 1;
      end
      default: begin
        if (!ls) begin
          n.phase = PH_PULSE; n.age = 0;
          n.losses = (m.losses < SAT) ? m.losses + 1 : SAT;
        end else if (s) begin
          n.phase = PH_PULSE; n.age = 0;
        end
      end
    endcase
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("a_pll_rst",    {31'b0, pll_rst_a},      {31'b0, ma.phase == PH_PULSE});
    checkOutput("a_core_reset", {31'b0, core_reset_a},   {31'b0, ma.phase != PH_UP});
    checkOutput("a_ready",      {31'b0, ready_a},        {31'b0, ma.phase == PH_UP});
    checkOutput("a_retry",      {24'b0, retry_count_a},  ma.retries);
    checkOutput("a_loss",       {24'b0, loss_count_a},   ma.losses);
    checkOutput("a_tseen",      {31'b0, timeout_seen_a}, {31'b0, ma.tseen});
    checkOutput("b_pll_rst",    {31'b0, pll_rst_b},      {31'b0, mb.phase == PH_PULSE});
    checkOutput("b_core_reset", {31'b0, core_reset_b},   {31'b0, mb.phase != PH_UP});
    checkOutput("b_ready",      {31'b0, ready_b},        {31'b0, mb.phase == PH_UP});
    checkOutput("b_retry",      {24'b0, retry_count_b},  mb.retries);
    checkOutput("b_loss",       {24'b0, loss_count_b},   mb.losses);
    checkOutput("b_tseen",      {31'b0, timeout_seen_b}, {31'b0, mb.tseen});
  endtask

  // Inputs change on the falling edge, the DUT samples them on the rising
  // edge, and outputs are compared on the following falling edge.
  task automatic applyStimulus(input bit r, input bit l, input bit s);
    rst            = r;
    pll_locked     = l;
    soft_reset_req = s;
    @(posedge clk);
    ma = mdlStep(ma, r, l, s, STB_A);
    mb = mdlStep(mb, r, l, s, STB_B);
    @(negedge clk);
    compareAll();
  endtask

  task automatic holdLock(input bit l, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, l, 1'b0);
  endtask

  initial begin
    int  mode;
    int  len;
    bit  reached;
    @(negedge clk);

    // Reset, then lock arrives ten cycles later and the core is released.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    holdLock(1'b0, 10);
    holdLock(1'b1, 12);
    checkOutput("t1_ready", {31'b0, ready_a}, 32'd1);

    // No lock at all: repeated pulses with the retry count climbing.
    holdLock(1'b0, 3 * (PULSE + TMO) + 6);
    checkOutput("t2_retry", {24'b0, retry_count_a}, 32'd3);

    // Lock glitch during qualification: five locked cycles, one drop, relock.
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdLock(1'b0, 6);
    holdLock(1'b1, 7);
    holdLock(1'b0, 1);
    holdLock(1'b1, 20);

    // Soft reset alone, then a soft reset coincident with the synced drop.
    applyStimulus(1'b0, 1'b1, 1'b1);
    holdLock(1'b1, 30);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    holdLock(1'b1, 30);

    // Randomized segments of lock behaviour, soft requests and resets.
    for (int seg = 0; seg < 200; seg++) begin
      mode = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      case (mode)
        0, 1, 2: for (int i = 0; i < len; i++)
                   applyStimulus(1'b0, 1'b1, ($urandom_range(0, 15) == 0));
        3, 4:    holdLock(1'b0, len);
        5, 6:    for (int i = 0; i < len % 10 + 1; i++)
                   applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        7: begin
          holdLock(1'b1, 30);
          applyStimulus(1'b0, 1'b0, 1'b0);
          applyStimulus(1'b0, 1'b0, 1'b0);
          applyStimulus(1'b0, 1'b0, 1'b1);
        end
        8:       applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        default: holdLock(1'b1, len);
      endcase
    end

    // Force more than 255 timeouts to saturate the retry counter.
    holdLock(1'b0, 300 * (PULSE + TMO) + 10);
    checkOutput("sat_retry_a", {24'b0, retry_count_a}, SAT);
    checkOutput("sat_retry_b", {24'b0, retry_count_b}, SAT);

    // Reset in the middle of WAIT_LOCK.
    reached = 1'b0;
    for (int i = 0; i < 2 * (PULSE + TMO); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (!pll_rst_a && core_reset_a) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("wait_reached", {31'b0, reached}, 32'd1);
    holdLock(1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("mid_rst_pll_rst", {31'b0, pll_rst_a},      32'd1);
    checkOutput("mid_rst_core",    {31'b0, core_reset_a},   32'd1);
    checkOutput("mid_rst_ready",   {31'b0, ready_a},        32'd0);
    checkOutput("mid_rst_retry",   {24'b0, retry_count_a},  32'd0);
    checkOutput("mid_rst_loss",    {24'b0, loss_count_a},   32'd0);
    checkOutput("mid_rst_tseen",   {31'b0, timeout_seen_a}, 32'd0);
    holdLock(1'b1, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
